btn_debounce_edge: RTL and testbench
====================================

Name: btn_debounce_edge

Overview:
Per-button input conditioning stage that sits directly upstream of the top-level LED/mode logic. It synchronises raw i_btn pins into the clock domain and debounces each one with an independent counter-based FSM. It produces clean level, one-cycle press/release strobes, and a press-toggled state. The mode-select and shift-direction logic consume these outputs in place of raw buttons.

Parameters:
NB_BTN, 4, number of independent button channels
NB_COUNTER, 14, width of each per-channel debounce counter
DEBOUNCE_LIM, 10000, consecutive stable cycles required to accept a level change; legal range 1..2**NB_COUNTER-1

Ports:
clock  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_btn  input  NB_BTN  raw asynchronous button pins
o_btn_level  output  NB_BTN  debounced level per channel
o_btn_press  output  NB_BTN  one-cycle strobe on accepted press
o_btn_release  output  NB_BTN  one-cycle strobe on accepted release
o_btn_toggle  output  NB_BTN  flips on every accepted press

Behaviour:
- Reset (sync, active-high, sampled on clock edge) clears everything for all channels: synchroniser flops = 0, counters = 0, state = RELEASED, all four outputs = 0. Reset has priority over all other activity, including mid-count and during an output strobe.
- Synchroniser: per bit, a two-flop chain ff1 <- i_btn, s <- ff1. The FSM sees only s.
- Per-channel FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: if s=1, go to PRESS_WAIT and set cnt=0; otherwise stay.
  - PRESS_WAIT:
    - If s=0, go to RELEASED and set cnt=0 (glitch rejected, no strobe).
    - Else if cnt==DEBOUNCE_LIM-1, go to PRESSED.
    - Else cnt++.
  - PRESSED: if s=0, go to RELEASE_WAIT and set cnt=0; otherwise stay.
  - RELEASE_WAIT:
    - If s=1, go to PRESSED and set cnt=0 (no strobe).
    - Else if cnt==DEBOUNCE_LIM-1, go to RELEASED.
    - Else cnt++.
- Outputs are all registered.
  - o_btn_level = 1 in PRESSED and RELEASE_WAIT.
  - o_btn_press is high for exactly the one cycle after the PRESS_WAIT->PRESSED transition edge.
  - o_btn_release is high for exactly the one cycle after the RELEASE_WAIT->RELEASED transition edge.
  - o_btn_toggle inverts on the same edge that asserts o_btn_press.
- Latency: pin stable high first captured by ff1 at edge t0 -> o_btn_level and o_btn_press rise after edge t0+2+DEBOUNCE_LIM. Release latency is identical.
- Counter never exceeds DEBOUNCE_LIM-1, so there is no wrap. Counter width must hold DEBOUNCE_LIM-1.
- DEBOUNCE_LIM=1: the wait state lasts exactly one cycle.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous strobes in the same cycle.
- o_btn_press and o_btn_release are never high together on the same channel.
- A held button yields a single press strobe, with no repeat.

Test Plan:
1. DEBOUNCE_LIM=4, reset, then i_btn[0] 0->1 held:
   - o_btn_level[0] and o_btn_press[0] rise 6 edges after first ff1 capture.
   - The press strobe lasts 1 cycle.
   - o_btn_toggle[0] goes 0->1.
2. DEBOUNCE_LIM=4, i_btn[1] high for 3 cycles then low (bounce), repeated 5 times:
   - o_btn_level[1], o_btn_press[1] and o_btn_toggle[1] stay 0 throughout.
3. Press and release i_btn[0] twice cleanly:
   - Exactly 2 press strobes and 2 release strobes appear, each release strobe 6 edges after the falling input.
   - o_btn_toggle[0] ends at 0.
4. Raise i_btn = 4'b1111 on the same edge:
   - All four o_btn_press bits pulse in the same cycle.
   - o_btn_level becomes 4'b1111.
5. Hold i_btn[2] high and assert i_reset for 1 cycle mid-PRESS_WAIT (cnt=2):
   - All outputs read 0 in the cycle after the reset edge.
   - With the button still held, a new press is accepted 2+DEBOUNCE_LIM edges after reset deasserts (pipeline refill).
6. While PRESSED, drop i_btn[3] for 2 cycles:
   - No release strobe.
   - o_btn_level[3] stays 1.
   - No second press strobe on return.

Source files
------------

// File: rtl/btn_debounce_edge.sv
// Button conditioning: two-flop synchroniser per pin, then a counter-based
// debounce FSM per channel producing level, press/release strobes and a toggle.
module btn_debounce_edge #(
    parameter int NB_BTN       = 4,
    parameter int NB_COUNTER   = 14,
    parameter int DEBOUNCE_LIM = 10000
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_press,
    output logic [NB_BTN-1:0] o_btn_release,
    output logic [NB_BTN-1:0] o_btn_toggle
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btnState_e;

    // Last count value of a wait state; reaching it accepts the new level.
    localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_LIM - 1);
    localparam logic [NB_COUNTER-1:0] CNT_ZERO = '0;
    localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);

    logic [NB_BTN-1:0] syncFf1_q;
    logic [NB_BTN-1:0] syncFf2_q;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            syncFf1_q <= '0;
            syncFf2_q <= '0;
        end else begin
            syncFf1_q <= i_btn;
            syncFf2_q <= syncFf1_q;
        end
    end

    for (genvar g = 0; g < NB_BTN; g++) begin : gChannel
        btnState_e             state_q;
        btnState_e             state_d;
        logic [NB_COUNTER-1:0] cnt_q;
        logic [NB_COUNTER-1:0] cnt_d;
        logic                  level_q;
        logic                  level_d;
        logic                  press_q;
        logic                  press_d;
        logic                  release_q;
        logic                  release_d;
        logic                  toggle_q;
        logic                  toggle_d;
        logic                  btnSync;

        assign btnSync = syncFf2_q[g];

        always_ff @(posedge clock) begin
            if (i_reset) begin
                state_q   <= RELEASED;
                cnt_q     <= CNT_ZERO;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                toggle_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                toggle_q  <= toggle_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                RELEASED: begin
                    if (btnSync) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ZERO;
                    end
                end
                PRESS_WAIT: begin
                    if (!btnSync) begin
                        state_d = RELEASED;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!btnSync) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ZERO;
                    end
                end
                RELEASE_WAIT: begin
                    if (btnSync) begin
                        state_d = PRESSED;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = RELEASED;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        // Outputs are decoded from the upcoming state so the registered
        // strobes appear in the cycle right after the accepting edge.
        always_comb begin
            level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
            release_d = (state_q == RELEASE_WAIT) && (state_d == RELEASED);
            toggle_d  = toggle_q ^ press_d;
        end

        assign o_btn_level[g]   = level_q;
        assign o_btn_press[g]   = press_q;
        assign o_btn_release[g] = release_q;
        assign o_btn_toggle[g]  = toggle_q;
    end

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Directed bench for btn_debounce_edge with DEBOUNCE_LIM=4; expected values
// are hand-derived from the synchroniser + debounce timing.
module tb_btn_debounce_edge;

    localparam int NB_BTN = 4;
    localparam int LIM    = 4;
    // Edges from an input change until the registered outputs show it.
    localparam int LAT    = LIM + 3;

    logic              clock;
    logic              reset;
    logic [NB_BTN-1:0] btnPins;
    logic [NB_BTN-1:0] btnLevel;
    logic [NB_BTN-1:0] btnPress;
    logic [NB_BTN-1:0] btnRelease;
    logic [NB_BTN-1:0] btnToggle;

    int vectorCount;
    int missCount;
    int pressCnt   [NB_BTN];
    int releaseCnt [NB_BTN];
    int strobeClash;
    int snapPress;
    int snapRelease;

    btn_debounce_edge #(
        .NB_BTN       (NB_BTN),
        .NB_COUNTER   (14),
        .DEBOUNCE_LIM (LIM)
    ) dut (
        .clock         (clock),
        .i_reset       (reset),
        .i_btn         (btnPins),
        .o_btn_level   (btnLevel),
        .o_btn_press   (btnPress),
        .o_btn_release (btnRelease),
        .o_btn_toggle  (btnToggle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent strobe tally, sampled mid-cycle away from the active edge.
    initial begin
        for (int i = 0; i < NB_BTN; i++) begin
            pressCnt[i]   = 0;
            releaseCnt[i] = 0;
        end
        strobeClash = 0;
    end

    always @(negedge clock) begin
        for (int i = 0; i < NB_BTN; i++) begin
            if (btnPress[i])                  pressCnt[i]++;
            if (btnRelease[i])                releaseCnt[i]++;
            if (btnPress[i] && btnRelease[i]) strobeClash++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [NB_BTN-1:0] pins, input logic rst);
        btnPins = pins;
        reset   = rst;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;

        // Reset state
        applyStimulus(4'b0000, 1'b1);
        tick(2);
        checkOutput("rst_level",   32'(btnLevel),   32'h0);
        checkOutput("rst_press",   32'(btnPress),   32'h0);
        checkOutput("rst_release", 32'(btnRelease), 32'h0);
        checkOutput("rst_toggle",  32'(btnToggle),  32'h0);
        applyStimulus(4'b0000, 1'b0);
        tick(2);

        // Test 1: clean press on channel 0
        applyStimulus(4'b0001, 1'b0);
        tick(LAT - 1);
        checkOutput("t1_level_early", 32'(btnLevel[0]), 32'h0);
        checkOutput("t1_press_early", 32'(btnPress[0]), 32'h0);
        tick(1);
        checkOutput("t1_level",  32'(btnLevel[0]),  32'h1);
        checkOutput("t1_press",  32'(btnPress[0]),  32'h1);
        checkOutput("t1_toggle", 32'(btnToggle[0]), 32'h1);
        tick(1);
        checkOutput("t1_press_1cyc", 32'(btnPress[0]), 32'h0);
        checkOutput("t1_level_hold", 32'(btnLevel[0]), 32'h1);

        // Test 2: bounces on channel 1 shorter than the debounce window
        for (int rep = 0; rep < 5; rep++) begin
            applyStimulus(4'b0011, 1'b0);
            for (int c = 0; c < 3; c++) begin
                tick(1);
                checkOutput("t2_ch1_hi", 32'({btnLevel[1], btnPress[1], btnToggle[1]}), 32'h0);
            end
            applyStimulus(4'b0001, 1'b0);
            for (int c = 0; c < 4; c++) begin
                tick(1);
                checkOutput("t2_ch1_lo", 32'({btnLevel[1], btnPress[1], btnToggle[1]}), 32'h0);
            end
        end
        checkOutput("t2_press_count", 32'(pressCnt[1]), 32'h0);

        // Test 3: release, press, release channel 0
        applyStimulus(4'b0000, 1'b0);
        tick(LAT - 1);
        checkOutput("t3_rel1_early", 32'({btnLevel[0], btnRelease[0]}), 32'h2);
        tick(1);
        checkOutput("t3_rel1", 32'({btnLevel[0], btnRelease[0]}), 32'h1);
        tick(1);
        checkOutput("t3_rel1_1cyc", 32'(btnRelease[0]), 32'h0);
        applyStimulus(4'b0001, 1'b0);
        tick(LAT);
        checkOutput("t3_press2",  32'(btnPress[0]),  32'h1);
        checkOutput("t3_toggle2", 32'(btnToggle[0]), 32'h0);
        applyStimulus(4'b0000, 1'b0);
        tick(LAT - 1);
        checkOutput("t3_rel2_early", 32'(btnRelease[0]), 32'h0);
        tick(1);
        checkOutput("t3_rel2", 32'({btnLevel[0], btnRelease[0]}), 32'h1);
        tick(2);
        checkOutput("t3_press_count",   32'(pressCnt[0]),   32'h2);
        checkOutput("t3_release_count", 32'(releaseCnt[0]), 32'h2);
        checkOutput("t3_toggle_end",    32'(btnToggle[0]),  32'h0);

        // Test 4: all channels pressed on the same edge
        applyStimulus(4'b1111, 1'b0);
        tick(LAT - 1);
        checkOutput("t4_press_early", 32'(btnPress), 32'h0);
        tick(1);
        checkOutput("t4_press_all",  32'(btnPress),  32'hF);
        checkOutput("t4_level_all",  32'(btnLevel),  32'hF);
        checkOutput("t4_toggle_all", 32'(btnToggle), 32'hF);
        tick(1);
        checkOutput("t4_press_1cyc", 32'(btnPress), 32'h0);

        // Test 6: short drop on channel 3 while pressed
        snapPress   = pressCnt[3];
        snapRelease = releaseCnt[3];
        applyStimulus(4'b0111, 1'b0);
        tick(2);
        applyStimulus(4'b1111, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick(1);
            checkOutput("t6_level3", 32'(btnLevel[3]), 32'h1);
        end
        checkOutput("t6_no_release", 32'(releaseCnt[3] - snapRelease), 32'h0);
        checkOutput("t6_no_repress", 32'(pressCnt[3] - snapPress),     32'h0);

        // Test 5: reset during PRESS_WAIT on channel 2
        applyStimulus(4'b0000, 1'b0);
        tick(LAT + 2);
        checkOutput("t5_all_released", 32'(btnLevel),      32'h0);
        checkOutput("t5_rel_count0",   32'(releaseCnt[0]), 32'h3);
        applyStimulus(4'b0100, 1'b0);
        tick(5);
        applyStimulus(4'b0100, 1'b1);
        tick(1);
        checkOutput("t5_rst_level",   32'(btnLevel),   32'h0);
        checkOutput("t5_rst_press",   32'(btnPress),   32'h0);
        checkOutput("t5_rst_release", 32'(btnRelease), 32'h0);
        checkOutput("t5_rst_toggle",  32'(btnToggle),  32'h0);
        applyStimulus(4'b0100, 1'b0);
        tick(LAT - 1);
        checkOutput("t5_refill_early", 32'(btnLevel[2]), 32'h0);
        tick(1);
        checkOutput("t5_press",  32'(btnPress),  32'h4);
        checkOutput("t5_level",  32'(btnLevel),  32'h4);
        checkOutput("t5_toggle", 32'(btnToggle), 32'h4);

        tick(2);
        checkOutput("press_release_clash", 32'(strobeClash), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
